// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one synchronous single-port SRAM between the CPU instruction-fetch
//   port (ice/iaddr/inst) and data port (dce/daddr/we/din/dm). Grants one side
//   per cycle, steers read data back to the side that issued the read, and
//   raises stallreq_arb whenever a presented request is refused this cycle.
//
// Ports
//   cpu_clk_50M, cpu_rst_n      clock; asynchronous active-low reset
//   ice, iaddr, inst            instruction read request / byte address / data
//   dce, daddr, we, din, dm     data request / byte address / byte enables /
//                               write data / read data
//   sram_en, sram_we, sram_addr, sram_wdata, sram_rdata
//                               SRAM interface, read data one cycle after a read
//   stallreq_arb                stall request to the stall control unit
module sram_port_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              ice,
  input  logic [31:0]       iaddr,
  output logic [31:0]       inst,
  input  logic              dce,
  input  logic [31:0]       daddr,
  input  logic [3:0]        we,
  input  logic [31:0]       din,
  output logic [31:0]       dm,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              stallreq_arb
);

  typedef enum logic [1:0] {
    NONE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } gnt_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  gnt_e        last_gnt;
  gnt_e        next_gnt;
  logic        i_served;
  logic        d_served;
  logic [3:0]  streak;
  logic [31:0] inst_q;
  logic [31:0] dm_q;

  logic        i_req;
  logic        d_req;
  logic        conflict;
  logic        at_max;
  logic        gnt_i;
  logic        gnt_d;

  // Address bits outside the word-address slice are deliberately ignored.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{iaddr, daddr};

  // Requests are masked by reset so every combinational output drops to its
  // idle value as soon as reset asserts, even with ice/dce still high.
  always_comb begin
    i_req    = ice & ~i_served & cpu_rst_n;
    d_req    = dce & ~d_served & cpu_rst_n;
    conflict = i_req & d_req;
    at_max   = (streak == STREAK_MAX);
    gnt_i    = i_req & (~d_req | at_max);
    gnt_d    = d_req & ~gnt_i;
  end

  always_comb begin
    sram_en      = 1'b0;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    next_gnt     = NONE;
    stallreq_arb = conflict;
    if (gnt_d) begin
      sram_en    = 1'b1;
      sram_we    = we;
      sram_addr  = daddr[ADDR_W+1:2];
      sram_wdata = din;
      next_gnt   = (|we) ? D_WR : D_RD;
    end else if (gnt_i) begin
      sram_en    = 1'b1;
      sram_addr  = iaddr[ADDR_W+1:2];
      sram_wdata = din;
      next_gnt   = I_RD;
    end
  end

  always_comb begin
    inst = (last_gnt == I_RD) ? sram_rdata : inst_q;
    dm   = (last_gnt == D_RD) ? sram_rdata : dm_q;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      last_gnt <= NONE;
      i_served <= 1'b0;
      d_served <= 1'b0;
      streak   <= '0;
      inst_q   <= '0;
      dm_q     <= '0;
    end else begin
      last_gnt <= next_gnt;
      // Served marks accumulate only within a stall episode; the first
      // non-stalled cycle ends the episode and clears both.
      if (conflict) begin
        i_served <= i_served | gnt_i;
        d_served <= d_served | gnt_d;
      end else begin
        i_served <= 1'b0;
        d_served <= 1'b0;
      end
      if (conflict && gnt_d)
        streak <= at_max ? streak : streak + 4'd1;
      else
        streak <= '0;
      if (last_gnt == I_RD)
        inst_q <= sram_rdata;
      if (last_gnt == D_RD)
        dm_q <= sram_rdata;
    end
  end

endmodule
